// File: rtl/rx_pkg.sv
// Shared types and constants for the rx serial receiver.
// Optional parity support is enabled by defining RX_PARITY_EN.
package rx_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter for rx: runs 0..CLKS_PER_BIT-1 while enabled and
// strobes mid_tick at the in-bit sample point and bit_end on the last cycle.
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk2,
   input  logic rst_n,
   input  logic run,
   output logic mid_tick,
   output logic bit_end
);

   localparam int MID = (CLKS_PER_BIT - 1) / 2;
   localparam int W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [W-1:0] cnt;

   // Held at zero while idle so the start-detect edge is always cycle 0.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign mid_tick = (cnt == W'(MID));
   assign bit_end  = (cnt == W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/rx.sv
// UART-style 8N1 receiver; last good byte on ledData, status on display.
// Define RX_PARITY_EN to expect an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// START  | start bit detected, re-checked at mid-bit for glitches
// DATA   | shifting in 8 data bits, LSB first
// PARITY | (RX_PARITY_EN only) sampling the even-parity bit
// STOP   | sampling stop bit, commit byte or flag frame error
module rx
   import rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk2,
   input  logic       rst_n,
   input  logic       transmission,
   output logic [7:0] ledData,
   output logic [4:0] display
);

   state_t     state, state_nxt;
   logic       mid_tick, bit_end, run;
   logic [2:0] idx;
   logic [7:0] shreg;
   logic [7:0] led_q;
   logic       ferr;
   logic       frame_ok;

   rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk2     (clk2),
      .rst_n    (rst_n),
      .run      (run),
      .mid_tick (mid_tick),
      .bit_end  (bit_end)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         // With one clock per bit the detect edge is also the start check.
         IDLE:   if (transmission != IDLE_LEVEL) state_nxt = bit_end ? DATA : START;
         START: begin
            if (mid_tick && transmission == IDLE_LEVEL) state_nxt = IDLE;
            else if (bit_end)                           state_nxt = DATA;
         end
`ifdef RX_PARITY_EN
         DATA:   if (bit_end && idx == 3'(DATA_BITS - 1)) state_nxt = PARITY;
         PARITY: if (bit_end) state_nxt = STOP;
`else
         DATA:   if (bit_end && idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
`endif
         STOP:   if (mid_tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      run = (state_nxt != IDLE);
   end

`ifdef RX_PARITY_EN
   logic perr;

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         perr <= 1'b0;
      end else if (state == PARITY && mid_tick) begin
         perr <= (^shreg) ^ transmission;
      end
   end

   assign frame_ok = (transmission == IDLE_LEVEL) && !perr;
`else
   assign frame_ok = (transmission == IDLE_LEVEL);
`endif

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         shreg <= '0;
         led_q <= '0;
         ferr  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DATA) begin
            if (mid_tick) shreg[idx] <= transmission;
            if (bit_end)  idx <= idx + 3'd1;
         end else begin
            idx <= '0;
         end
         if (state == STOP && mid_tick) begin
            if (frame_ok) begin
               led_q <= shreg;
               ferr  <= 1'b0;
            end else begin
               ferr  <= 1'b1;
            end
         end
      end
   end

   assign ledData = led_q;
   assign display = {state != IDLE, ferr, (state == DATA) ? idx : 3'd0};

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: one-clock-per-bit and four-clock-per-bit
// instances, scoreboard of expected bytes compared at each frame end.
module tb_rx;

   logic       clk2  = 1'b0;
   logic       rst_n = 1'b1;
   logic       line  = 1'b1;
   logic       line4 = 1'b1;
   logic [7:0] led, led4;
   logic [4:0] disp, disp4;

   always #5 clk2 = ~clk2;

   rx #(.CLKS_PER_BIT(1)) dut (
      .clk2(clk2), .rst_n(rst_n), .transmission(line), .ledData(led), .display(disp)
   );

   rx #(.CLKS_PER_BIT(4)) dut4 (
      .clk2(clk2), .rst_n(rst_n), .transmission(line4), .ledData(led4), .display(disp4)
   );

   typedef struct {
      logic [7:0] led;
      logic       ferr;
   } exp_t;

   exp_t       sbq[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] model_led   = 8'h00;
   bit         prev_busy   = 1'b0;

   // Scoreboard: one entry popped each time the receiver leaves a frame.
   always @(negedge clk2) begin
      exp_t e;
      if (!rst_n) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && !disp[4]) begin
            vectors++;
            if (sbq.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_frame led=%h ferr=%b with empty scoreboard", led, disp[3]);
            end else begin
               e = sbq.pop_front();
               if (led !== e.led || disp[3] !== e.ferr) begin
                  miscompares++;
                  $display("FAIL frame_result got led=%h ferr=%b expected led=%h ferr=%b",
                           led, disp[3], e.led, e.ferr);
               end
            end
         end
         prev_busy = disp[4];
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      if (stop) model_led = d;
      e.led  = model_led;
      e.ferr = !stop;
      sbq.push_back(e);
      @(negedge clk2) line = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk2) line = d[i];
      @(negedge clk2) line = stop;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk2) line = 1'b1;
   endtask

   task automatic drain();
      int waited = 0;
      while (sbq.size() != 0 && waited < 40) begin
         @(negedge clk2);
         waited++;
      end
      if (sbq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout %0d frames still pending, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic test_reset();
      @(posedge clk2);
      #2 rst_n = 1'b0;
      #1;
      vectors += 4;
      if (led !== 8'h00) begin miscompares++; $display("FAIL reset_led got %h expected 00", led); end
      if (disp !== 5'b00000) begin miscompares++; $display("FAIL reset_display got %b expected 00000", disp); end
      if (led4 !== 8'h00) begin miscompares++; $display("FAIL reset_led4 got %h expected 00", led4); end
      if (disp4 !== 5'b00000) begin miscompares++; $display("FAIL reset_display4 got %b expected 00000", disp4); end
      @(negedge clk2);
      @(posedge clk2);
      #2 rst_n = 1'b1;
      model_led = 8'h00;
   endtask

   task automatic test_latency();
      logic [9:0] frame;
      exp_t       e;
      frame  = {1'b1, 8'h22, 1'b0};
      idle(5);
      model_led = 8'h22;
      e.led  = 8'h22;
      e.ferr = 1'b0;
      sbq.push_back(e);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk2);
         if (k == 4) begin
            vectors++;
            if (disp !== 5'b10011) begin miscompares++; $display("FAIL data_index got %b expected 10011", disp); end
         end
         if (k == 9) begin
            vectors++;
            if (led !== 8'h00) begin miscompares++; $display("FAIL early_update got %h expected 00", led); end
         end
         line = frame[k];
      end
      @(negedge clk2);
      vectors++;
      if (led !== 8'h22 || disp[4] !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_9 got led=%h busy=%b expected led=22 busy=0", led, disp[4]);
      end
      line = 1'b1;
      drain();
   endtask

   task automatic test_frames();
      idle(5);
      send_frame(8'h48, 1'b1);
      idle(2);
      drain();
      send_frame(8'hFF, 1'b0);
      idle(3);
      drain();
      vectors++;
      if (disp !== 5'b01000) begin miscompares++; $display("FAIL sticky_ferr got %b expected 01000", disp); end
      send_frame(8'h01, 1'b1);
      idle(2);
      drain();
      vectors++;
      if (disp !== 5'b00000) begin miscompares++; $display("FAIL ferr_clear got %b expected 00000", disp); end
   endtask

   task automatic test_back_to_back();
      idle(2);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      idle(2);
      drain();
      vectors++;
      if (led !== 8'hC3) begin miscompares++; $display("FAIL back_to_back got %h expected c3", led); end
   endtask

   task automatic test_slow_frame();
      logic [9:0] frame;
      frame = {1'b1, 8'h96, 1'b0};
      for (int k = 0; k < 40; k++) begin
         @(negedge clk2);
         if (k == 22) begin
            vectors++;
            if (disp4 !== 5'b10100) begin miscompares++; $display("FAIL slow_index got %b expected 10100", disp4); end
         end
         if (k == 37) begin
            vectors++;
            if (led4 !== 8'h00) begin miscompares++; $display("FAIL slow_early got %h expected 00", led4); end
         end
         line4 = frame[k / 4];
      end
      @(negedge clk2);
      vectors++;
      if (led4 !== 8'h96 || disp4 !== 5'b00000) begin
         miscompares++;
         $display("FAIL slow_latency got led=%h disp=%b expected led=96 disp=00000", led4, disp4);
      end
      line4 = 1'b1;
   endtask

   task automatic test_glitch();
      int busy_cycles = 0;
      repeat (3) @(negedge clk2);
      line4 = 1'b0;
      @(negedge clk2) line4 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (disp4[4]) busy_cycles++;
         @(negedge clk2);
      end
      vectors += 3;
      if (busy_cycles < 1 || busy_cycles > 2) begin
         miscompares++;
         $display("FAIL glitch_busy got %0d cycles expected 1..2", busy_cycles);
      end
      if (led4 !== 8'h96) begin miscompares++; $display("FAIL glitch_led got %h expected 96", led4); end
      if (disp4 !== 5'b00000) begin miscompares++; $display("FAIL glitch_display got %b expected 00000", disp4); end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] frame;
      frame = {1'b1, 8'h5A, 1'b0};
      idle(3);
      for (int k = 0; k < 6; k++) @(negedge clk2) line = frame[k];
      @(posedge clk2);
      #2 rst_n = 1'b0;
      #1;
      vectors += 2;
      if (led !== 8'h00) begin miscompares++; $display("FAIL midreset_led got %h expected 00", led); end
      if (disp !== 5'b00000) begin miscompares++; $display("FAIL midreset_display got %b expected 00000", disp); end
      model_led = 8'h00;
      @(negedge clk2) line = 1'b1;
      @(posedge clk2);
      #2 rst_n = 1'b1;
      idle(3);
      send_frame(8'hA5, 1'b1);
      idle(2);
      drain();
      vectors++;
      if (led !== 8'hA5) begin miscompares++; $display("FAIL after_reset got %h expected a5", led); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_frames();
      test_back_to_back();
      test_slow_frame();
      test_glitch();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
